// File: rtl/ir_command_sequencer.sv
`default_nettype none
// ============================================================================
// ir_command_sequencer : bus-loaded FIFO of (command, duration) entries that
// plays each command on COMMAND for duration * TICK_DIV clock cycles.
// Revision: 1.0
// ============================================================================
module ir_command_sequencer #(
  parameter int                   BUS_WIDTH  = 8,
  parameter logic [BUS_WIDTH-1:0] BASE_ADDR  = 8'h94,
  parameter int                   CMD_LEN    = 4,
  parameter int                   FIFO_DEPTH = 8,
  parameter int                   TICK_DIV   = 10_000_000
) (
  input  logic                 CLK,
  input  logic                 RESET,
  inout  wire  [BUS_WIDTH-1:0] BUS_DATA,
  input  logic [BUS_WIDTH-1:0] BUS_ADDR,
  input  logic                 BUS_WE,
  output logic [CMD_LEN-1:0]   COMMAND,
  output logic                 DONE_IRQ
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = CMD_LEN + 4;
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [BUS_WIDTH-1:0] CTRL_ADDR = BASE_ADDR + 1'b1;
  localparam logic [CNT_W-1:0]     DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(TICK_DIV - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [ENT_W-1:0]     mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]     mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 run_q, run_d;
  logic                 ovf_q, ovf_d;
  logic [CMD_LEN-1:0]   cmd_q, cmd_d;
  logic [3:0]           rem_q, rem_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 done_q, done_d;
  logic                 rd_en_q, rd_en_d;
  logic [BUS_WIDTH-1:0] rd_data_q, rd_data_d;

  logic                 w_entry_sel, w_ctrl_sel, w_entry_wr, w_ctrl_wr, w_flush;
  logic [3:0]           w_wr_dur;
  logic [CMD_LEN-1:0]   w_wr_cmd;
  logic                 w_empty, w_full, w_push, w_pop, w_tick;
  logic [ENT_W-1:0]     w_head;
  logic [BUS_WIDTH-1:0] w_status;

  assign w_entry_sel = (BUS_ADDR == BASE_ADDR);
  assign w_ctrl_sel  = (BUS_ADDR == CTRL_ADDR);
  assign w_entry_wr  = BUS_WE && w_entry_sel;
  assign w_ctrl_wr   = BUS_WE && w_ctrl_sel;
  assign w_flush     = w_ctrl_wr && BUS_DATA[1];
  assign w_wr_dur    = BUS_DATA[7:4];
  assign w_wr_cmd    = BUS_DATA[CMD_LEN-1:0];
  assign w_empty     = (count_q == '0);
  assign w_full      = (count_q == DEPTH_CNT);
  // Fullness is judged before any same-cycle pop, so a push at full is always dropped.
  assign w_push      = w_entry_wr && (w_wr_dur != 4'd0) && !w_full;
  assign w_tick      = (div_q == DIV_LAST);
  assign w_head      = mem_q[rd_ptr_q];
  assign w_status    = {4'(count_q), ovf_q, w_full, w_empty, (state_q == ST_PLAY)};

  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    run_d     = run_q;
    ovf_d     = ovf_q;
    cmd_d     = cmd_q;
    rem_d     = rem_q;
    div_d     = div_q;
    done_d    = 1'b0;
    w_pop     = 1'b0;
    rd_en_d   = !BUS_WE && (w_entry_sel || w_ctrl_sel);
    rd_data_d = w_entry_sel ? BUS_WIDTH'(cmd_q) : w_status;

    case (state_q)
      ST_IDLE: begin
        cmd_d = '0;
        div_d = '0;
        if (run_q && !w_empty) w_pop = 1'b1;
      end
      ST_PLAY: begin
        div_d = w_tick ? '0 : div_q + 1'b1;
        if (w_tick) begin
          if (rem_q == 4'd1) begin
            if (run_q && !w_empty) begin
              w_pop = 1'b1;
            end else begin
              state_d = ST_IDLE;
              cmd_d   = '0;
              done_d  = w_empty;
            end
          end else begin
            rem_d = rem_q - 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_pop) begin
      state_d  = ST_PLAY;
      cmd_d    = w_head[CMD_LEN-1:0];
      rem_d    = w_head[ENT_W-1:CMD_LEN];
      div_d    = '0;
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (w_push) begin
      mem_d[wr_ptr_q] = {w_wr_dur, w_wr_cmd};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end

    count_d = count_q + {{(CNT_W-1){1'b0}}, w_push} - {{(CNT_W-1){1'b0}}, w_pop};

    if (w_entry_wr && (w_wr_dur != 4'd0) && w_full) ovf_d = 1'b1;
    // The read data above already holds the old OVF, so clearing here is safe.
    if (!BUS_WE && w_ctrl_sel) ovf_d = 1'b0;
    if (w_ctrl_wr) run_d = BUS_DATA[0];

    if (w_flush) begin
      state_d  = ST_IDLE;
      cmd_d    = '0;
      rem_d    = '0;
      div_d    = '0;
      done_d   = 1'b0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      run_q     <= 1'b0;
      ovf_q     <= 1'b0;
      cmd_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      run_q     <= run_d;
      ovf_q     <= ovf_d;
      cmd_q     <= cmd_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign COMMAND  = cmd_q;
  assign DONE_IRQ = done_q;
  assign BUS_DATA = rd_en_q ? rd_data_q : {BUS_WIDTH{1'bz}};

endmodule

`default_nettype wire

// File: tb/tb_ir_command_sequencer.sv
`default_nettype none
// ============================================================================
// tb_ir_command_sequencer : vector table, directed playback sequences and
// random bus traffic checked against a queue-based playback model.
// Revision: 1.0
// ============================================================================
module tb_ir_command_sequencer;

  localparam int         TD   = 4;
  localparam logic [7:0] BASE = 8'h94;
  localparam logic [7:0] CTRL = 8'h95;
  localparam logic [7:0] IDLE_BUS = 8'hFF;  // undriven bus reads high through the pullups

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic [7:0] addr;
  logic       drv_en;
  logic [7:0] drv_data;
  wire  [7:0] bus;
  logic [3:0] cmd;
  logic       done;

  assign bus = drv_en ? drv_data : 8'bz;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pull
      pullup (bus[gi]);
    end
  endgenerate

  always #5 clk = ~clk;

  ir_command_sequencer #(
    .BUS_WIDTH (8),
    .BASE_ADDR (BASE),
    .CMD_LEN   (4),
    .FIFO_DEPTH(8),
    .TICK_DIV  (TD)
  ) dut (
    .CLK     (clk),
    .RESET   (rst),
    .BUS_DATA(bus),
    .BUS_ADDR(addr),
    .BUS_WE  (we),
    .COMMAND (cmd),
    .DONE_IRQ(done)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: queue of entries, cycles left on the current one
  logic [7:0] mq[$];
  bit         m_run, m_ovf, m_play, m_done;
  logic [3:0] m_cmd;
  int         m_left;

  task automatic model_reset();
    mq.delete();
    m_run = 0; m_ovf = 0; m_play = 0; m_done = 0; m_cmd = 4'h0; m_left = 0;
  endtask

  function automatic logic [7:0] m_status();
    int n;
    n = mq.size();
    return {4'(n), m_ovf, (n == 8), (n == 0), m_play};
  endfunction

  task automatic model_edge(input logic w, input logic [7:0] a, input logic [7:0] d,
                            output logic [7:0] exp_bus);
    int         n0;
    bit         run0, start;
    logic [7:0] e;
    n0    = mq.size();
    run0  = m_run;
    start = 0;
    if (w)              exp_bus = d;
    else if (a == BASE) exp_bus = {4'h0, m_cmd};
    else if (a == CTRL) exp_bus = m_status();
    else                exp_bus = IDLE_BUS;

    m_done = 0;
    if (w && a == CTRL) m_run = d[0];
    if (w && a == CTRL && d[1]) begin
      mq.delete();
      m_play = 0; m_cmd = 4'h0; m_left = 0;
    end else begin
      if (m_play) begin
        m_left--;
        if (m_left == 0) begin
          if (run0 && n0 > 0) start = 1;
          else begin
            m_play = 0; m_cmd = 4'h0; m_done = (n0 == 0);
          end
        end
      end else if (run0 && n0 > 0) begin
        start = 1;
      end
      if (start) begin
        e      = mq.pop_front();
        m_cmd  = e[3:0];
        m_left = int'(e[7:4]) * TD;
        m_play = 1;
      end
    end
    if (w && a == BASE && d[7:4] != 4'h0) begin
      if (n0 == 8) m_ovf = 1;
      else         mq.push_back(d);
    end
    if (!w && a == CTRL) m_ovf = 0;
  endtask

  // ---------------- bus driver with per-cycle checking
  logic [7:0] last_bus;
  bit         last_rd;
  int         done_cnt = 0;
  logic [3:0] trace[$];

  task automatic do_cycle(input logic w, input logic [7:0] a, input logic [7:0] d);
    logic [7:0] exp_bus;
    we = w; addr = a; drv_en = w; drv_data = d;
    @(posedge clk);
    model_edge(w, a, d, exp_bus);
    #1;
    check("command", 32'(cmd), 32'(m_cmd));
    check("done_irq", 32'(done), 32'(m_done));
    check("bus_data", 32'(bus), 32'(exp_bus));
    last_bus = bus;
    trace.push_back(cmd);
    if (done) done_cnt++;
    last_rd = !w && (a == BASE || a == CTRL);
  endtask

  // A read is answered in the following cycle, so a write right after it needs a turnaround.
  task automatic bus_op(input logic w, input logic [7:0] a, input logic [7:0] d);
    if (w && last_rd) do_cycle(1'b0, 8'h00, 8'h00);
    do_cycle(w, a, d);
  endtask

  task automatic idle(input int n);
    repeat (n) do_cycle(1'b0, 8'h00, 8'h00);
  endtask

  // Splits the trace into runs of equal non-zero commands; gap flags a zero between runs.
  int seg_c[$];
  int seg_l[$];
  int gap;

  task automatic analyze();
    int v, prev;
    bit started, ended;
    seg_c.delete(); seg_l.delete();
    gap = 0; prev = 0; started = 0; ended = 0;
    foreach (trace[i]) begin
      v = int'(trace[i]);
      if (v != 0) begin
        if (ended) gap = 1;
        if (started && v == prev) seg_l[seg_l.size()-1] = seg_l[seg_l.size()-1] + 1;
        else begin
          seg_c.push_back(v);
          seg_l.push_back(1);
        end
        started = 1;
      end else if (started) begin
        ended = 1;
      end
      prev = v;
    end
  endtask

  task automatic check_seg(input string name, input int k, input int c, input int l);
    if (k < seg_c.size()) begin
      check({name, "_cmd"}, 32'(seg_c[k]), 32'(c));
      check({name, "_len"}, 32'(seg_l[k]), 32'(l));
    end else begin
      check({name, "_missing"}, 32'(seg_c.size()), 32'(k + 1));
    end
  endtask

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
    logic       chk;
    logic [7:0] exp;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl[NV];

  function automatic vec_t mk(input logic w, input logic [7:0] a, input logic [7:0] d,
                              input logic c, input logic [7:0] x);
    vec_t v;
    v.we = w; v.addr = a; v.data = d; v.chk = c; v.exp = x;
    return v;
  endfunction

  initial begin
    #1_000_000;
    check("watchdog_expired", 32'd1, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    int d0, r;
    bit found;
    logic [7:0] rd;

    tbl[0]  = mk(0, CTRL, 8'h00, 1, 8'h02);   // reset status
    tbl[1]  = mk(0, BASE, 8'h00, 1, 8'h00);   // ENTRY read shows stop
    tbl[2]  = mk(1, BASE, 8'h07, 0, 8'h00);   // duration 0 dropped
    tbl[3]  = mk(0, CTRL, 8'h00, 1, 8'h02);
    for (int i = 0; i < 9; i++) tbl[4+i] = mk(1, BASE, 8'h11 + 8'(i), 0, 8'h00);
    tbl[13] = mk(0, CTRL, 8'h00, 1, 8'h8C);   // full with OVF
    tbl[14] = mk(0, CTRL, 8'h00, 1, 8'h84);   // OVF cleared by previous read
    tbl[15] = mk(0, 8'h96, 8'h00, 1, IDLE_BUS);
    tbl[16] = mk(1, 8'h93, 8'h5A, 0, 8'h00);
    tbl[17] = mk(0, CTRL, 8'h00, 1, 8'h84);

    rst = 1'b1; we = 1'b0; addr = 8'h00; drv_en = 1'b0; drv_data = 8'h00;
    last_rd = 0; last_bus = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_command", 32'(cmd), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_bus", 32'(bus), 32'(IDLE_BUS));
    @(negedge clk);
    rst = 1'b0;

    // register vectors and overflow
    for (int i = 0; i < NV; i++) begin
      bus_op(tbl[i].we, tbl[i].addr, tbl[i].data);
      if (tbl[i].chk) check($sformatf("table%0d", i), 32'(last_bus), 32'(tbl[i].exp));
    end

    // the eight accepted entries play back-to-back; the ninth never appears
    trace.delete(); d0 = done_cnt;
    bus_op(1, CTRL, 8'h01);
    idle(8 * TD + 8);
    analyze();
    check("ovf_segments", 32'(seg_c.size()), 32'd8);
    for (int k = 0; k < 8; k++) check_seg($sformatf("ovf_seg%0d", k), k, k + 1, TD);
    check("ovf_gap", 32'(gap), 32'd0);
    check("ovf_done", 32'(done_cnt - d0), 32'd1);

    // single entry
    trace.delete(); d0 = done_cnt;
    bus_op(1, BASE, 8'h35);
    check("single_push_edge", 32'(cmd), 32'd0);
    idle(1);
    check("single_load_edge", 32'(cmd), 32'd5);
    idle(3 * TD + 4);
    analyze();
    check("single_segments", 32'(seg_c.size()), 32'd1);
    check_seg("single", 0, 5, 3 * TD);
    check("single_done", 32'(done_cnt - d0), 32'd1);
    bus_op(0, CTRL, 8'h00);
    check("single_status", 32'(last_bus), 32'h02);

    // back-to-back
    bus_op(1, CTRL, 8'h00);
    bus_op(1, BASE, 8'h21);
    bus_op(1, BASE, 8'h12);
    bus_op(1, BASE, 8'h14);
    trace.delete(); d0 = done_cnt;
    bus_op(1, CTRL, 8'h01);
    idle(4 * TD + 6);
    analyze();
    check("b2b_segments", 32'(seg_c.size()), 32'd3);
    check_seg("b2b0", 0, 1, 2 * TD);
    check_seg("b2b1", 1, 2, TD);
    check_seg("b2b2", 2, 4, TD);
    check("b2b_gap", 32'(gap), 32'd0);
    check("b2b_done", 32'(done_cnt - d0), 32'd1);

    // flush during the first entry
    bus_op(1, CTRL, 8'h00);
    bus_op(1, BASE, 8'h23);
    bus_op(1, BASE, 8'h24);
    bus_op(1, BASE, 8'h25);
    bus_op(1, CTRL, 8'h01);
    idle(3);
    check("flush_pre", 32'(cmd), 32'd3);
    d0 = done_cnt;
    bus_op(1, CTRL, 8'h03);
    check("flush_cmd", 32'(cmd), 32'd0);
    bus_op(0, CTRL, 8'h00);
    check("flush_status", 32'(last_bus), 32'h02);
    trace.delete();
    idle(20);
    analyze();
    check("flush_stays_idle", 32'(seg_c.size()), 32'd0);
    check("flush_done", 32'(done_cnt - d0), 32'd0);
    trace.delete();
    bus_op(1, BASE, 8'h16);
    idle(TD + 3);
    analyze();
    check("flush_newpush_segments", 32'(seg_c.size()), 32'd1);
    check_seg("flush_newpush", 0, 6, TD);

    // RUN cleared during the second of three entries
    bus_op(1, CTRL, 8'h00);
    bus_op(1, BASE, 8'h21);
    bus_op(1, BASE, 8'h22);
    bus_op(1, BASE, 8'h23);
    trace.delete(); d0 = done_cnt;
    bus_op(1, CTRL, 8'h01);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      idle(1);
      if (cmd == 4'd2) found = 1;
    end
    check("runclr_reached_second", 32'(found), 32'd1);
    bus_op(1, CTRL, 8'h00);
    idle(3 * TD);
    analyze();
    check("runclr_segments", 32'(seg_c.size()), 32'd2);
    check_seg("runclr0", 0, 1, 2 * TD);
    check_seg("runclr1", 1, 2, 2 * TD);
    check("runclr_done", 32'(done_cnt - d0), 32'd0);
    bus_op(0, CTRL, 8'h00);
    check("runclr_status", 32'(last_bus), 32'h10);
    trace.delete(); d0 = done_cnt;
    bus_op(1, CTRL, 8'h01);
    idle(3 * TD);
    analyze();
    check("runclr_resume_segments", 32'(seg_c.size()), 32'd1);
    check_seg("runclr_resume", 0, 3, 2 * TD);
    check("runclr_resume_done", 32'(done_cnt - d0), 32'd1);

    // asynchronous reset in the middle of an entry
    bus_op(1, BASE, 8'h3F);
    idle(10);
    check("areset_pre", 32'(cmd), 32'd15);
    #2;
    rst = 1'b1;
    #1;
    check("areset_cmd_immediate", 32'(cmd), 32'd0);
    check("areset_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    last_rd = 0;
    bus_op(0, CTRL, 8'h00);
    check("areset_status", 32'(last_bus), 32'h02);
    bus_op(0, BASE, 8'h00);
    check("areset_entry_read", 32'(last_bus), 32'h00);
    trace.delete();
    bus_op(1, BASE, 8'h11);
    idle(2 * TD);
    analyze();
    check("areset_run_cleared", 32'(seg_c.size()), 32'd0);
    bus_op(1, BASE, 8'h0A);
    bus_op(0, CTRL, 8'h00);
    check("zero_dur_ignored", 32'(last_bus), 32'h10);

    // random traffic against the model
    bus_op(1, CTRL, 8'h01);
    for (int it = 0; it < 1500; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 10) begin
        bus_op(1, BASE, 8'($urandom));
      end else if (r < 14) begin
        rd = {6'($urandom), ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0)};
        bus_op(1, CTRL, rd);
      end else if (r < 22) begin
        bus_op(0, CTRL, 8'h00);
      end else if (r < 26) begin
        bus_op(0, BASE, 8'h00);
      end else if (r < 30) begin
        bus_op(1'($urandom), 8'($urandom), 8'($urandom));
      end else begin
        idle(1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
